// File: rtl/tcb_arb_3mp_if.sv
// Purpose: bundle of the three manager-facing request/response channels plus the single subordinate channel.
// Latency: none; this file is wiring only.
// Backpressure: man_rdy flows back to the granted sub_rdy; responses follow one cycle after each transfer.
// Ports: sub_* are the PN manager ports (vectors indexed by port), man_* is the downstream subordinate.
//   modport slave  : view of the arbiter (accepts sub_* requests, drives man_* requests)
//   modport master : view of the environment (drives sub_* requests, acts as the subordinate)
interface tcb_arb_3mp_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int PN = 3
);
  localparam int BW = DW / 8;

  // manager-side request/response, one lane per port
  logic [PN-1:0]          sub_vld;
  logic [PN-1:0]          sub_wen;
  logic [PN-1:0][BW-1:0]  sub_ben;
  logic [PN-1:0][AW-1:0]  sub_adr;
  logic [PN-1:0][DW-1:0]  sub_wdt;
  logic [PN-1:0]          sub_rdy;
  logic [PN-1:0][DW-1:0]  sub_rdt;
  logic [PN-1:0]          sub_err;

  // single subordinate request/response
  logic                   man_vld;
  logic                   man_wen;
  logic [BW-1:0]          man_ben;
  logic [AW-1:0]          man_adr;
  logic [DW-1:0]          man_wdt;
  logic                   man_rdy;
  logic [DW-1:0]          man_rdt;
  logic                   man_err;

  modport slave (
    input  sub_vld, sub_wen, sub_ben, sub_adr, sub_wdt,
    output sub_rdy, sub_rdt, sub_err,
    output man_vld, man_wen, man_ben, man_adr, man_wdt,
    input  man_rdy, man_rdt, man_err
  );

  modport master (
    output sub_vld, sub_wen, sub_ben, sub_adr, sub_wdt,
    input  sub_rdy, sub_rdt, sub_err,
    input  man_vld, man_wen, man_ben, man_adr, man_wdt,
    output man_rdy, man_rdt, man_err
  );
endinterface

// File: rtl/tcb_arb_3mp.sv
// Purpose: round-robin arbiter merging three TCB manager ports onto one subordinate.
// Latency: request path is combinational (zero cycles); response routed one cycle after transfer.
// Backpressure: only the granted port sees man_rdy; a stalled grant is held until it transfers.
// Ports: clk, rst (sync, active-high); bus (tcb_arb_3mp_if.slave) carries all request/response lanes.
module tcb_arb_3mp #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int PN  = 3,
  parameter int DLY = 1
) (
  input  logic           clk,
  input  logic           rst,
  tcb_arb_3mp_if.slave   bus
);

  if (PN != 3) begin : g_bad_pn
    $error("tcb_arb_3mp: only PN=3 is implemented");
  end
  if (DLY != 1) begin : g_bad_dly
    $error("tcb_arb_3mp: only DLY=1 is implemented");
  end

  typedef enum logic {
    ST_ARB  = 1'b0,  // grant follows round-robin search
    ST_HOLD = 1'b1   // grant frozen on lock_idx until the stalled request transfers
  } state_t;

  state_t          state;
  logic [1:0]      ptr;
  logic [1:0]      lock_idx;
  logic [1:0]      rsp_sel;

  logic [1:0]      rr_gnt;
  logic [1:0]      gnt;
  logic            rr_found;
  logic [2:0]      rr_sum;
  logic [1:0]      rsp_eff;
  logic            man_trn;

  logic [AW-1:0]   adr_sel;
  logic [DW-1:0]   wdt_sel;
  logic [DW/8-1:0] ben_sel;
  logic [PN-1:0]   rdy_vec;

  // first asserted request starting at ptr, wrapping modulo 3
  always_comb begin
    rr_gnt   = ptr;
    rr_found = 1'b0;
    rr_sum   = 3'd0;
    for (int k = 0; k < 3; k++) begin
      rr_sum = {1'b0, ptr} + 3'(k);
      if (rr_sum >= 3'd3) rr_sum = rr_sum - 3'd3;
      if (!rr_found && bus.sub_vld[rr_sum[1:0]]) begin
        rr_gnt   = rr_sum[1:0];
        rr_found = 1'b1;
      end
    end
  end

  assign gnt = (state == ST_HOLD) ? lock_idx : rr_gnt;

  // with nothing requesting, gnt points at an idle port so man_vld falls to 0 by itself
  assign bus.man_vld = !rst && bus.sub_vld[gnt];
  assign adr_sel     = bus.sub_adr[gnt];
  assign wdt_sel     = bus.sub_wdt[gnt];
  assign ben_sel     = bus.sub_ben[gnt];
  assign bus.man_adr = adr_sel;
  assign bus.man_wdt = wdt_sel;
  assign bus.man_ben = ben_sel;
  assign bus.man_wen = bus.sub_wen[gnt];
  assign man_trn     = bus.man_vld && bus.man_rdy;

  always_comb begin
    rdy_vec      = '0;
    rdy_vec[gnt] = bus.man_vld && bus.man_rdy;
  end
  assign bus.sub_rdy = rdy_vec;

  // during reset the response mux already points at port 0
  assign rsp_eff = rst ? 2'd0 : rsp_sel;

  always_comb begin
    for (int i = 0; i < PN; i++) begin
      bus.sub_rdt[i] = (rsp_eff == 2'(i)) ? bus.man_rdt : '0;
      bus.sub_err[i] = (rsp_eff == 2'(i)) ? bus.man_err : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ARB;
      ptr      <= 2'd0;
      lock_idx <= 2'd0;
      rsp_sel  <= 2'd0;
    end else if (man_trn) begin
      state    <= ST_ARB;
      ptr      <= (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
      rsp_sel  <= gnt;
    end else if (bus.man_vld) begin
      state    <= ST_HOLD;
      lock_idx <= gnt;
    end
  end

endmodule

// File: doc/tcb_arb_3mp.md
TCB_ARB_3MP -- requirements
Module: tcb_arb_3mp

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width; BW=DW/8 byte enables.
REQ-003 SHALL have parameter PN, default 3, manager port count (fixed, not to be changed).
REQ-004 SHALL have parameter DLY, default 1, response delay in cycles after transfer (only 1 supported).
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 sub_vld  in  PN  request valid per manager.
REQ-008 sub_wen  in  PN  write enable per manager.
REQ-009 sub_ben  in  PN x BW  byte enables per manager.
REQ-010 sub_adr  in  PN x AW  address per manager.
REQ-011 sub_wdt  in  PN x DW  write data per manager.
REQ-012 sub_rdy  out  PN  request accepted, per manager.
REQ-013 sub_rdt  out  PN x DW  read data per manager (response phase).
REQ-014 sub_err  out  PN  error per manager (response phase).
REQ-015 man_vld/man_wen/man_ben/man_adr/man_wdt  out  1/1/BW/AW/DW  request to the single subordinate.
REQ-016 man_rdy  in  1  subordinate ready.
REQ-017 man_rdt/man_err  in  DW/1  subordinate response, DLY cycles after transfer.

Function
REQ-018 Transfer (trn) SHALL be vld & rdy in the same cycle, on each side.
REQ-019 Grant index gnt SHALL be: lock index when lock=1; else first asserted sub_vld searched ptr, ptr+1, ptr+2 (mod 3).
REQ-020 With no sub_vld asserted and lock=0: man_vld=0, all sub_rdy=0, man_wen/ben/adr/wdt don't-care.
REQ-021 man_vld and request fields SHALL be combinational copies of sub[gnt] (zero added latency).
REQ-022 sub_rdy[gnt]=man_rdy; sub_rdy[i]=0 for i!=gnt, combinational.
REQ-023 Lock: when man_vld=1 and man_rdy=0, SHALL set lock=1 and store lock index=gnt; cleared on the cycle man transfer occurs.
REQ-024 While lock=1 the grant SHALL NOT change even if higher-priority ports assert vld.
REQ-025 Round-robin pointer ptr (2 bits, values 0..2): on man transfer by port g, ptr <= (g+1) mod 3 (2 wraps to 0); unchanged otherwise.
REQ-026 Response select rsp_sel (2 bits) SHALL register gnt on each man transfer; unchanged otherwise.
REQ-027 sub_rdt[i]=man_rdt and sub_err[i]=man_err when rsp_sel==i; else sub_rdt[i]=0, sub_err[i]=0.
REQ-028 Back-to-back transfers SHALL be supported: one transfer per cycle, response of cycle N routed in N+1 while request N+1 proceeds.
REQ-029 Simultaneous requests from all 3 ports with man_rdy=1 continuously SHALL be served in strict rotation, one per cycle.
REQ-030 A manager deasserting vld while locked is a protocol violation; behaviour undefined, no recovery required.

Reset
REQ-031 On rst=1 at a clock edge: ptr=0, lock=0, lock index=0, rsp_sel=0.
REQ-032 During rst: man_vld=0, all sub_rdy=0, all sub_rdt=0 except port 0 follows man_rdt, sub_err likewise.
REQ-033 Reset mid-wait (lock=1) SHALL drop the lock; in-flight response is discarded by the system.

Verification
REQ-034 After reset, sub_vld=3'b111, man_rdy=1 for 3 cycles -> transfers granted to ports 0,1,2; ptr ends at 0.
REQ-035 sub_vld=3'b010 only, man_rdy=1, read adr=0x100, man_rdt=0xCAFE0001 next cycle -> sub_rdt[1]=0xCAFE0001, sub_rdt[0]=sub_rdt[2]=0.
REQ-036 Port 0 requests, man_rdy=0 for 3 cycles, port 2 asserts vld in cycle 1 -> grant stays 0, sub_rdy[2]=0 until port 0 transfers in cycle 4; port 2 granted in cycle 5.
REQ-037 ptr=2, sub_vld=3'b101 -> port 2 granted first, then port 0 (wrap-around).
REQ-038 Write with ben=4'b0011 from port 1, man_err=1 on response -> sub_err[1]=1, sub_err[0]=sub_err[2]=0.
REQ-039 rst asserted while lock=1 -> next cycle lock=0, ptr=0, man_vld follows new arbitration from port 0.
